axi_burst_injector: RTL and testbench
=====================================

AXI_BURST_INJECTOR -- requirements
Module: axi_burst_injector

Interface
REQ-001 The block SHALL have one clock, aclock, and one reset, areset; areset is synchronous and active-high.
REQ-002 ADDR_WIDTH, default 32, address width.
REQ-003 DATA_WIDTH, default 256, data width in bits (power of two, 32 to 1024).
REQ-004 MAX_OUTSTANDING, default 4, maximum bursts in flight (1 to 16).
REQ-005 aclock  in  1  clock.
REQ-006 areset  in  1  sync active-high reset.
REQ-007 cmd_valid  in  1  command valid.
REQ-008 cmd_ready  out  1  command accepted when high with cmd_valid.
REQ-009 cmd_write  in  1  1=write burst, 0=read-check burst.
REQ-010 cmd_addr  in  ADDR_WIDTH  burst start address.
REQ-011 cmd_len  in  8  beats minus one.
REQ-012 awaddr, awlen, awvalid  out  ADDR_WIDTH, 8, 1  AXI write request; awready  in  1.
REQ-013 wdata, wlast, wvalid  out  DATA_WIDTH, 1, 1  AXI write data; wready  in  1.
REQ-014 bresp, bvalid  in  2, 1  write response; bready  out  1.
REQ-015 araddr, arlen, arvalid  out  ADDR_WIDTH, 8, 1  AXI read request; arready  in  1.
REQ-016 rdata, rresp, rlast, rvalid  in  DATA_WIDTH, 2, 1, 1  read response; rready  out  1.
REQ-017 busy  out  1  any command, beat or response pending.
REQ-018 mismatch_count  out  16  saturating count of mismatching read beats.
REQ-019 resp_error  out  1  sticky error flag.

Function
REQ-020 Burst type SHALL be INCR with full-width size; a single implicit ID SHALL be used, so responses arrive in order.
REQ-021 Address handling: cmd_addr low log2(DATA_WIDTH/8) bits SHALL be forced to zero; beat k address = aligned base + k*DATA_WIDTH/8; 4 KiB crossings SHALL be issued unchanged.
REQ-022 Data pattern: beat k data SHALL be the beat-k address, zero-extended to 32 bits and replicated across DATA_WIDTH.
REQ-023 Write FSM states and transitions: IDLE -> ADDR on write command handshake; ADDR -> DATA on awready; DATA -> IDLE on the wlast handshake; wvalid SHALL NOT assert before the AW handshake.
REQ-024 Read FSM states and transitions: IDLE -> ADDR on read command handshake; ADDR -> IDLE on arready; {base, len} SHALL be pushed to an expectation FIFO of depth MAX_OUTSTANDING at the AR handshake.
REQ-025 cmd_ready SHALL equal: outstanding < MAX_OUTSTANDING, and the target FSM (write or read, per cmd_write) in IDLE.
REQ-026 Latency: awvalid/arvalid SHALL assert the cycle after the command handshake and hold until ready.
REQ-027 Outstanding counter: +1 on AW or AR handshake; -1 on B handshake or R handshake with rlast; simultaneous increment and decrement SHALL leave it unchanged.
REQ-028 Read check: each R beat SHALL be compared against the pattern of the FIFO head; the head SHALL pop on rlast; mismatch_count SHALL increment per differing beat and saturate at 0xFFFF.
REQ-029 bready and rready SHALL be 1 whenever areset is low.
REQ-030 resp_error SHALL set on either: bresp/rresp != OKAY; or an R beat arriving with the FIFO empty. It SHALL clear only on areset.
REQ-031 busy SHALL equal: either FSM not IDLE, or outstanding != 0.

Reset
REQ-032 On areset both FSMs SHALL go to IDLE, outstanding and mismatch_count to 0, the FIFO to empty and resp_error to 0; all valid outputs and cmd_ready SHALL be 0 while areset is high. Reset mid-burst SHALL abandon the burst with no further beats.

Structure
REQ-033 Package axi_injector_pkg SHALL hold the AXI resp encodings (OKAY=0, EXOKAY=1, SLVERR=2, DECERR=3) and the FSM state enums.
REQ-034 The expectation FIFO SHALL be a sub-module named injector_fifo.

Verification (DATA_WIDTH=256)
REQ-035 Write 0x1000 len 3 -> awaddr 0x1000, awlen 3 next cycle; data words 0x1000, 0x1020, 0x1040, 0x1060; wlast on beat 4; after B OKAY, busy=0.
REQ-036 Read-check 0x1000 len 3, correct data -> mismatch_count 0; beat 2 corrupted -> mismatch_count 1.
REQ-037 MAX_OUTSTANDING=4, five reads, R withheld -> cmd_ready=0 after the 4th AR handshake; it SHALL return to 1 after the first rlast.
REQ-038 bresp=SLVERR -> resp_error=1, held until areset.
REQ-039 B handshake and AR handshake in the same cycle -> outstanding unchanged.
REQ-040 areset after write beat 2 -> wvalid=0 and busy=0 the next cycle; no further beats.

Source files
------------

// File: rtl/axi_injector_pkg.sv
// Shared AXI response encodings and FSM state types for the burst injector.
package axi_injector_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'd0,
    RESP_EXOKAY = 2'd1,
    RESP_SLVERR = 2'd2,
    RESP_DECERR = 2'd3
  } axi_resp_t;

  typedef enum logic [1:0] {
    WR_IDLE = 2'd0,
    WR_ADDR = 2'd1,
    WR_DATA = 2'd2
  } wr_state_t;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_ADDR = 1'b1
  } rd_state_t;

endpackage

// File: rtl/injector_fifo.sv
// Expectation FIFO holding {base, len} of issued read bursts, popped on rlast.
module injector_fifo #(
  parameter int WIDTH = 40,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count;
  logic             full, do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/axi_burst_injector.sv
// AXI INCR burst generator: writes an address-derived pattern and checks it on reads.
// Handshake: a transfer happens on a rising edge where valid and ready are both high.
module axi_burst_injector
  import axi_injector_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 256,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                  aclock,
  input  logic                  areset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [7:0]            cmd_len,
  output logic [ADDR_WIDTH-1:0] awaddr,
  output logic [7:0]            awlen,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic                  wlast,
  output logic                  wvalid,
  input  logic                  wready,
  input  logic [1:0]            bresp,
  input  logic                  bvalid,
  output logic                  bready,
  output logic [ADDR_WIDTH-1:0] araddr,
  output logic [7:0]            arlen,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic [1:0]            rresp,
  input  logic                  rlast,
  input  logic                  rvalid,
  output logic                  rready,
  output logic                  busy,
  output logic [15:0]           mismatch_count,
  output logic                  resp_error,
  output logic [1:0]            wr_state,
  output logic                  rd_state
);
  localparam int BYTES     = DATA_WIDTH / 8;
  localparam int LOG_BYTES = $clog2(BYTES);
  localparam int WORDS     = DATA_WIDTH / 32;
  localparam int OUT_W     = $clog2(MAX_OUTSTANDING + 2);
  localparam int ENTRY_W   = ADDR_WIDTH + 8;

  function automatic logic [DATA_WIDTH-1:0] beat_pattern(input logic [ADDR_WIDTH-1:0] addr);
    logic [31:0] word;
    word = 32'(addr);
    return {WORDS{word}};
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] beat_addr(input logic [ADDR_WIDTH-1:0] base,
                                                      input logic [7:0] idx);
    return base + (ADDR_WIDTH'(idx) << LOG_BYTES);
  endfunction

  wr_state_t             wr_q, wr_d;
  rd_state_t             rd_q, rd_d;
  logic [ADDR_WIDTH-1:0] wr_base, rd_base, aligned, head_base;
  logic [7:0]            wr_len, rd_len, wr_beat, r_beat, head_len;
  logic [OUT_W-1:0]      outstanding, out_sum;
  logic [1:0]            inc, dec;
  logic [ENTRY_W-1:0]    head;
  logic                  fifo_empty, cmd_fire, aw_fire, w_fire, b_fire, ar_fire, r_fire, r_done;

  assign aligned  = cmd_addr & ~ADDR_WIDTH'(BYTES - 1);
  assign cmd_ready = !areset && (outstanding < OUT_W'(MAX_OUTSTANDING)) &&
                     (cmd_write ? (wr_q == WR_IDLE) : (rd_q == RD_IDLE));
  assign cmd_fire = cmd_valid && cmd_ready;
  assign aw_fire  = awvalid && awready;
  assign w_fire   = wvalid && wready;
  assign b_fire   = bvalid && bready;
  assign ar_fire  = arvalid && arready;
  assign r_fire   = rvalid && rready;
  assign r_done   = r_fire && rlast && !fifo_empty;
  assign bready   = !areset;
  assign rready   = !areset;
  assign busy     = (wr_q != WR_IDLE) || (rd_q != RD_IDLE) || (outstanding != '0);
  assign wr_state = wr_q;
  assign rd_state = rd_q;

  always_ff @(posedge aclock) begin
    if (areset) begin
      wr_q <= WR_IDLE;
      rd_q <= RD_IDLE;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_comb begin
    wr_d = wr_q;
    case (wr_q)
      WR_IDLE: if (cmd_fire && cmd_write) wr_d = WR_ADDR;
      WR_ADDR: if (aw_fire) wr_d = WR_DATA;
      WR_DATA: if (w_fire && wlast) wr_d = WR_IDLE;
      default: wr_d = WR_IDLE;
    endcase
    rd_d = rd_q;
    case (rd_q)
      RD_IDLE: if (cmd_fire && !cmd_write) rd_d = RD_ADDR;
      RD_ADDR: if (ar_fire) rd_d = RD_IDLE;
      default: rd_d = RD_IDLE;
    endcase
  end

  // Valids are gated by reset so nothing leaves the block while areset is high.
  always_comb begin
    awvalid = !areset && (wr_q == WR_ADDR);
    awaddr  = wr_base;
    awlen   = wr_len;
    wvalid  = !areset && (wr_q == WR_DATA);
    wdata   = beat_pattern(beat_addr(wr_base, wr_beat));
    wlast   = (wr_beat == wr_len);
    arvalid = !areset && (rd_q == RD_ADDR);
    araddr  = rd_base;
    arlen   = rd_len;
  end

  always_ff @(posedge aclock) begin
    if (areset) begin
      wr_base <= '0;
      wr_len  <= '0;
      wr_beat <= '0;
      rd_base <= '0;
      rd_len  <= '0;
    end else begin
      if (cmd_fire && cmd_write) begin
        wr_base <= aligned;
        wr_len  <= cmd_len;
      end
      if (cmd_fire && !cmd_write) begin
        rd_base <= aligned;
        rd_len  <= cmd_len;
      end
      if (aw_fire)     wr_beat <= '0;
      else if (w_fire) wr_beat <= wr_beat + 8'd1;
    end
  end

  // AW and AR may complete together, as may B and a final R beat.
  assign inc     = {1'b0, aw_fire} + {1'b0, ar_fire};
  assign dec     = {1'b0, b_fire} + {1'b0, r_done};
  assign out_sum = outstanding + OUT_W'(inc);

  always_ff @(posedge aclock) begin
    if (areset)                     outstanding <= '0;
    else if (OUT_W'(dec) > out_sum) outstanding <= '0;
    else                            outstanding <= out_sum - OUT_W'(dec);
  end

  injector_fifo #(.WIDTH(ENTRY_W), .DEPTH(MAX_OUTSTANDING)) u_fifo (
    .clk       (aclock),
    .rst       (areset),
    .push      (ar_fire),
    .push_data ({rd_base, rd_len}),
    .pop       (r_done),
    .head      (head),
    .empty     (fifo_empty)
  );

  assign {head_base, head_len} = head;

  // Beat index parks at the burst length if a slave sends more beats than requested.
  always_ff @(posedge aclock) begin
    if (areset) begin
      r_beat         <= '0;
      mismatch_count <= '0;
      resp_error     <= 1'b0;
    end else begin
      if (b_fire && (bresp != RESP_OKAY)) resp_error <= 1'b1;
      if (r_fire && ((rresp != RESP_OKAY) || fifo_empty)) resp_error <= 1'b1;
      if (r_fire && !fifo_empty) begin
        if ((rdata != beat_pattern(beat_addr(head_base, r_beat))) &&
            (mismatch_count != 16'hFFFF))
          mismatch_count <= mismatch_count + 16'd1;
        if (rlast)                    r_beat <= '0;
        else if (r_beat != head_len)  r_beat <= r_beat + 8'd1;
      end
    end
  end
endmodule

// File: tb/tb_axi_burst_injector.sv
// Directed bench for axi_burst_injector with a queue-based scoreboard on AW/W/AR.
module tb_axi_burst_injector;
  localparam int AW = 32;
  localparam int DW = 256;
  localparam int MO = 4;

  logic          aclock, areset;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [7:0]    cmd_len;
  logic [AW-1:0] awaddr, araddr;
  logic [7:0]    awlen, arlen;
  logic          awvalid, awready, wlast, wvalid, wready;
  logic [DW-1:0] wdata, rdata;
  logic [1:0]    bresp, rresp;
  logic          bvalid, bready, arvalid, arready, rlast, rvalid, rready;
  logic          busy, resp_error;
  logic [15:0]   mismatch_count;
  logic [1:0]    wr_state;
  logic          rd_state;

  axi_burst_injector #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MO)) dut (
    .aclock(aclock), .areset(areset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .awaddr(awaddr), .awlen(awlen), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arlen(arlen), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .busy(busy), .mismatch_count(mismatch_count), .resp_error(resp_error),
    .wr_state(wr_state), .rd_state(rd_state)
  );

  // clock / reset
  initial aclock = 1'b0;
  always #5 aclock = ~aclock;

  // scoreboard
  logic [AW+7:0] aw_exp_q[$];
  logic [DW:0]   w_exp_q[$];
  logic [AW+7:0] ar_exp_q[$];
  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [DW:0] act, input logic [DW:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    checks++;
    $display("FAIL %s: event seen/missing, expected otherwise", name);
  endtask

  function automatic logic [DW-1:0] pat(input logic [31:0] a);
    return {8{a}};
  endfunction

  always @(negedge aclock) begin
    if (!areset) begin
      if (awvalid && awready) begin
        if (aw_exp_q.size() == 0) fail_now("aw_unexpected");
        else check("aw_req", {awaddr, awlen}, aw_exp_q.pop_front());
      end
      if (wvalid && wready) begin
        if (w_exp_q.size() == 0) fail_now("w_unexpected");
        else check("w_beat", {wlast, wdata}, w_exp_q.pop_front());
      end
      if (arvalid && arready) begin
        if (ar_exp_q.size() == 0) fail_now("ar_unexpected");
        else check("ar_req", {araddr, arlen}, ar_exp_q.pop_front());
      end
    end
  end

  // driver tasks: each starts and ends 1 time unit after a rising edge
  task automatic tick();
    @(posedge aclock);
    #1;
  endtask

  task automatic push_write(input logic [31:0] base, input logic [7:0] len);
    aw_exp_q.push_back({base, len});
    for (int k = 0; k <= int'(len); k++)
      w_exp_q.push_back({(k == int'(len)), pat(base + 32'(k * 32))});
  endtask

  task automatic push_read(input logic [31:0] base, input logic [7:0] len);
    ar_exp_q.push_back({base, len});
  endtask

  task automatic send_cmd(input logic wr, input logic [31:0] addr, input logic [7:0] len);
    int n = 0;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_len = len;
    @(negedge aclock);
    while (!cmd_ready && n < 50) begin
      @(negedge aclock);
      n++;
    end
    if (!cmd_ready) fail_now("cmd_timeout");
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_drain(input int sel, input int left);
    int n = 0;
    while (((sel == 0) ? w_exp_q.size() : ar_exp_q.size()) > left && n < 50) begin
      tick();
      n++;
    end
    if (((sel == 0) ? w_exp_q.size() : ar_exp_q.size()) > left)
      fail_now((sel == 0) ? "w_timeout" : "ar_timeout");
  endtask

  task automatic b_resp(input logic [1:0] r);
    bvalid = 1'b1; bresp = r;
    tick();
    bvalid = 1'b0; bresp = 2'd0;
  endtask

  task automatic r_beat(input logic [DW-1:0] d, input logic last, input logic [1:0] r);
    rvalid = 1'b1; rdata = d; rlast = last; rresp = r;
    tick();
    rvalid = 1'b0; rlast = 1'b0; rresp = 2'd0;
  endtask

  task automatic r_burst(input logic [31:0] base, input logic [7:0] len, input int corrupt);
    logic [DW-1:0] d;
    for (int k = 0; k <= int'(len); k++) begin
      d = pat(base + 32'(k * 32));
      if (k == corrupt) d = ~d;
      r_beat(d, (k == int'(len)), 2'd0);
    end
  endtask

  task automatic do_reset();
    areset = 1'b1;
    tick();
    areset = 1'b0;
    tick();
  endtask

  initial begin
    #100000;
    fail_now("global_timeout");
    $display("%0d/%0d checks passed", passes, checks);
    $fatal(1, "timeout");
  end

  initial begin
    areset = 1'b1; cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = '0; cmd_len = '0;
    awready = 1'b1; wready = 1'b1; arready = 1'b1;
    bvalid = 1'b0; bresp = 2'd0; rvalid = 1'b0; rdata = '0; rresp = 2'd0; rlast = 1'b0;
    repeat (3) tick();
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_awvalid", awvalid, 0);
    check("rst_wr_state", wr_state, 0);
    cmd_valid = 1'b0;
    areset = 1'b0;
    tick();
    check("idle_busy", busy, 0);
    check("idle_mismatch", mismatch_count, 0);
    check("idle_resp_error", resp_error, 0);
    check("idle_cmd_ready", cmd_ready, 1);
    check("idle_b_r_ready", {bready, rready}, 2'b11);

    // write 0x1000 len 3 with AW held off one cycle
    awready = 1'b0;
    push_write(32'h1000, 8'd3);
    send_cmd(1'b1, 32'h1000, 8'd3);
    check("aw_latency", awvalid, 1);
    check("w_before_aw", wvalid, 0);
    awready = 1'b1;
    wait_drain(0, 0);
    check("busy_before_b", busy, 1);
    b_resp(2'd0);
    check("busy_after_b", busy, 0);

    // unaligned start crossing a 4 KiB boundary
    push_write(32'h1FC0, 8'd3);
    send_cmd(1'b1, 32'h1FD3, 8'd3);
    wait_drain(0, 0);
    b_resp(2'd0);

    // read-check, clean then one corrupted beat
    push_read(32'h1000, 8'd3);
    send_cmd(1'b0, 32'h1000, 8'd3);
    wait_drain(1, 0);
    r_burst(32'h1000, 8'd3, -1);
    check("rd_clean_mismatch", mismatch_count, 0);
    push_read(32'h1000, 8'd3);
    send_cmd(1'b0, 32'h1007, 8'd3);
    wait_drain(1, 0);
    r_burst(32'h1000, 8'd3, 1);
    check("rd_corrupt_mismatch", mismatch_count, 1);
    check("rd_busy_done", busy, 0);

    // outstanding limit with R withheld
    for (int i = 0; i < 4; i++) begin
      push_read(32'h3000 + 32'(i * 256), 8'd0);
      send_cmd(1'b0, 32'h3000 + 32'(i * 256), 8'd0);
      wait_drain(1, 0);
    end
    push_read(32'h3400, 8'd0);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h3400; cmd_len = 8'd0;
    @(negedge aclock);
    check("cmd_ready_full", cmd_ready, 0);
    tick();
    r_beat(pat(32'h3000), 1'b1, 2'd0);
    check("cmd_ready_after_rlast", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
    wait_drain(1, 0);
    for (int i = 1; i < 5; i++) r_burst(32'h3000 + 32'(i * 256), 8'd0, -1);
    check("limit_mismatch", mismatch_count, 1);
    check("limit_busy", busy, 0);

    // B and AR handshakes in the same cycle
    push_write(32'h5000, 8'd0);
    send_cmd(1'b1, 32'h5000, 8'd0);
    wait_drain(0, 0);
    push_read(32'h6000, 8'd0);
    send_cmd(1'b0, 32'h6000, 8'd0);
    wait_drain(1, 0);
    arready = 1'b0;
    push_read(32'h6100, 8'd0);
    send_cmd(1'b0, 32'h6100, 8'd0);
    arready = 1'b1; bvalid = 1'b1; bresp = 2'd0;
    tick();
    bvalid = 1'b0;
    cmd_write = 1'b0;
    #1;
    check("cmd_ready_after_b_ar", cmd_ready, 1);
    push_read(32'h6200, 8'd0);
    send_cmd(1'b0, 32'h6200, 8'd0);
    wait_drain(1, 0);
    check("cmd_ready_at_3", cmd_ready, 1);
    push_read(32'h6300, 8'd0);
    send_cmd(1'b0, 32'h6300, 8'd0);
    wait_drain(1, 0);
    check("cmd_ready_at_4", cmd_ready, 0);
    for (int i = 0; i < 4; i++) r_burst(32'h6000 + 32'(i * 256), 8'd0, -1);
    check("sim_busy", busy, 0);

    // SLVERR is sticky until reset
    check("err_before", resp_error, 0);
    push_write(32'h8000, 8'd1);
    send_cmd(1'b1, 32'h8000, 8'd1);
    wait_drain(0, 0);
    b_resp(2'd2);
    check("err_slverr", resp_error, 1);
    repeat (5) tick();
    check("err_held", resp_error, 1);
    do_reset();
    check("err_cleared", {resp_error, mismatch_count}, 17'd0);

    // bad rresp, then stray R beat with nothing expected
    push_read(32'h9000, 8'd0);
    send_cmd(1'b0, 32'h9000, 8'd0);
    wait_drain(1, 0);
    r_beat(pat(32'h9000), 1'b1, 2'd3);
    check("err_rresp", {resp_error, mismatch_count}, {1'b1, 16'd0});
    do_reset();
    r_beat(pat(32'h0), 1'b1, 2'd0);
    check("err_stray_r", resp_error, 1);
    do_reset();

    // reset after the second write beat
    push_write(32'h7000, 8'd3);
    send_cmd(1'b1, 32'h7000, 8'd3);
    wait_drain(0, 2);
    areset = 1'b1;
    w_exp_q.delete();
    #1;
    check("wvalid_in_reset", {wvalid, cmd_ready}, 2'b00);
    @(posedge aclock);
    #1;
    areset = 1'b0;
    #1;
    check("wvalid_after_reset", wvalid, 0);
    check("busy_after_reset", busy, 0);
    repeat (10) tick();
    check("no_beats_after_reset", {busy, wvalid, awvalid}, 3'b000);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
